mem_lsu: RTL and testbench

Memory-stage load/store unit of the five-stage RV32I pipeline. It consumes the EX/MEM outputs (`aluop`, `sub_aluop`, effective address, store data, destination register) and performs loads and stores over the byte-wide RAM port, one byte per cycle. While an access is in flight it holds the pipeline through `mem_stall`. It returns sign- or zero-extended load data toward MEM/WB; non-memory instructions pass straight through.

---
 rtl/mem_lsu_pkg.sv | 56 +++++
 rtl/mem_lsu_if.sv | 49 ++++
 rtl/mem_lsu_load_ext.sv | 21 ++
 rtl/mem_lsu.sv | 150 +++++++++++++++
 tb/tb_mem_lsu.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/mem_lsu_pkg.sv
// mem_lsu_pkg: shared types and constants for the memory-stage load/store unit.
// Holds the pipeline bus widths, the major/sub op codes consumed from EX/MEM,
// the LSU FSM state encoding and the access-size encoding, plus helpers that
// decode a sub-op into its size and signedness.
package mem_lsu_pkg;

    typedef logic [31:0] reg_bus_t;       // RegBus
    typedef logic [4:0]  reg_addr_bus_t;  // RegAddrBus
    typedef logic [7:0]  op_bus_t;        // OpBus
    typedef logic [7:0]  sub_op_bus_t;    // SubOpBus

    // Major ops from EX/MEM
    localparam op_bus_t EXE_NOP   = 8'h00;
    localparam op_bus_t EXE_ARITH = 8'h01;
    localparam op_bus_t EXE_LB    = 8'h02;  // any load
    localparam op_bus_t EXE_SB    = 8'h03;  // any store

    // Sub ops
    localparam sub_op_bus_t OP_NOP = 8'h00;
    localparam sub_op_bus_t OP_ADD = 8'h01;
    localparam sub_op_bus_t OP_LB  = 8'h10;
    localparam sub_op_bus_t OP_LH  = 8'h11;
    localparam sub_op_bus_t OP_LW  = 8'h12;
    localparam sub_op_bus_t OP_LBU = 8'h13;
    localparam sub_op_bus_t OP_LHU = 8'h14;
    localparam sub_op_bus_t OP_SB  = 8'h18;
    localparam sub_op_bus_t OP_SH  = 8'h19;
    localparam sub_op_bus_t OP_SW  = 8'h1A;

    typedef enum logic [1:0] {
        LSU_IDLE    = 2'd0,
        LSU_ACCESS  = 2'd1,
        LSU_COLLECT = 2'd2
    } lsu_state_e;

    // Encoded as the index of the last byte (n-1), so it compares directly
    // against the byte counter.
    typedef enum logic [1:0] {
        LSU_SZ_B = 2'd0,
        LSU_SZ_H = 2'd1,
        LSU_SZ_W = 2'd3
    } lsu_size_e;

    function automatic lsu_size_e lsu_size(input sub_op_bus_t sub);
        case (sub)
            OP_LH, OP_LHU, OP_SH: return LSU_SZ_H;
            OP_LW, OP_SW:         return LSU_SZ_W;
            default:              return LSU_SZ_B;
        endcase
    endfunction

    function automatic logic lsu_signed(input sub_op_bus_t sub);
        return (sub == OP_LB) || (sub == OP_LH);
    endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// mem_lsu_if: bundles the EX/MEM-side signals, the MEM/WB-side writeback
// signals, the stall request and the byte-wide RAM port of mem_lsu.
//   slave  : the LSU view (pipeline inputs in, writeback/stall/RAM out)
//   master : the surrounding pipeline + RAM view
// misalign_o exists only when MEM_LSU_MISALIGN_TRAP_EN is defined.
interface mem_lsu_if
    import mem_lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) ();
    op_bus_t       aluop_i;
    sub_op_bus_t   sub_aluop_i;
    reg_bus_t      mem_addr_i;
    reg_bus_t      reg2_i;
    reg_addr_bus_t wd_i;
    logic          wreg_i;
    reg_bus_t      wdata_i;
    reg_addr_bus_t wd_o;
    logic          wreg_o;
    reg_bus_t      wdata_o;
    logic          mem_stall;
    logic [ADDR_W-1:0] ram_addr_o;
    logic          ram_wr_o;
    logic [7:0]    ram_dout_o;
    logic [7:0]    ram_din_i;
`ifdef MEM_LSU_MISALIGN_TRAP_EN
    logic          misalign_o;
`endif

    modport slave (
`ifdef MEM_LSU_MISALIGN_TRAP_EN
        output misalign_o,
`endif
        input  aluop_i, sub_aluop_i, mem_addr_i, reg2_i, wd_i, wreg_i, wdata_i,
        output wd_o, wreg_o, wdata_o, mem_stall,
        output ram_addr_o, ram_wr_o, ram_dout_o,
        input  ram_din_i
    );

    modport master (
`ifdef MEM_LSU_MISALIGN_TRAP_EN
        input  misalign_o,
`endif
        output aluop_i, sub_aluop_i, mem_addr_i, reg2_i, wd_i, wreg_i, wdata_i,
        input  wd_o, wreg_o, wdata_o, mem_stall,
        input  ram_addr_o, ram_wr_o, ram_dout_o,
        output ram_din_i
    );
endinterface

// File: rtl/mem_lsu_load_ext.sv
// mem_load_ext: combinational load-data assembly and extension.
// Ports: lanes (bytes 0..2 captured earlier), last_byte (final byte taken
// straight from the RAM read port), size, is_signed -> data (32-bit result).
module mem_load_ext
    import mem_lsu_pkg::*;
(
    input  logic [23:0] lanes,
    input  logic [7:0]  last_byte,
    input  lsu_size_e   size,
    input  logic        is_signed,
    output reg_bus_t    data
);
    always_comb begin
        data = '0;
        case (size)
            LSU_SZ_B: data = {{24{is_signed & last_byte[7]}}, last_byte};
            LSU_SZ_H: data = {{16{is_signed & last_byte[7]}}, last_byte, lanes[7:0]};
            default:  data = {last_byte, lanes};
        endcase
    end
endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: memory-stage load/store unit, one RAM byte per cycle, little-endian.
// Ports: clk, rst (asynchronous, active-low), bus (mem_lsu_if.slave: EX/MEM
// inputs, MEM/WB writeback, mem_stall, byte RAM port).
// Optional feature macro: MEM_LSU_MISALIGN_TRAP_EN (misaligned H/W accesses
// trap via misalign_o instead of being performed bytewise).
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic      clk,
    input  logic      rst,
    mem_lsu_if.slave  bus
);
    lsu_state_e  state_reg, state_next;
    logic [1:0]  cnt_reg, cnt_next;
    logic [1:0]  byte_idx;
    logic        cap_en;
    logic [1:0]  cap_idx;
    logic [23:0] lanes;
    reg_bus_t    load_data;
    lsu_size_e   sz;
    logic        is_load, is_store, is_mem, misaligned;

    logic              stall_c, wr_c, wreg_c;
    logic [ADDR_W-1:0] addr_c;
    logic [7:0]        dout_c;
    reg_bus_t          wdata_c;

    assign is_load  = (bus.aluop_i == EXE_LB);
    assign is_store = (bus.aluop_i == EXE_SB);
    assign is_mem   = is_load | is_store;
    assign sz       = lsu_size(bus.sub_aluop_i);

`ifdef MEM_LSU_MISALIGN_TRAP_EN
    // Checked only at the start of an access; a trapped op never leaves IDLE.
    assign misaligned = (state_reg == LSU_IDLE) && is_mem &&
                        (((sz == LSU_SZ_H) && bus.mem_addr_i[0]) ||
                         ((sz == LSU_SZ_W) && (bus.mem_addr_i[1:0] != 2'b00)));
    assign bus.misalign_o = rst & misaligned;
`else
    assign misaligned = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= LSU_IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Byte k of a load returns one cycle after its address, so the cycle
    // issuing byte k captures byte k-1. The final byte is never stored.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_lane
            logic [7:0] lane_reg;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst)
                    lane_reg <= '0;
                else if (cap_en && (cap_idx == 2'(gi)))
                    lane_reg <= bus.ram_din_i;
            end
            assign lanes[gi*8 +: 8] = lane_reg;
        end
    endgenerate

    mem_load_ext u_load_ext (
        .lanes     (lanes),
        .last_byte (bus.ram_din_i),
        .size      (sz),
        .is_signed (lsu_signed(bus.sub_aluop_i)),
        .data      (load_data)
    );

    // IDLE with a memory op acts as ACCESS with cnt = 0, so there is no
    // start-up bubble.
    assign byte_idx = (state_reg == LSU_ACCESS) ? cnt_reg : 2'd0;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        cap_en     = 1'b0;
        cap_idx    = 2'(byte_idx - 2'd1);
        stall_c    = 1'b0;
        wr_c       = 1'b0;
        addr_c     = '0;
        dout_c     = '0;
        wreg_c     = bus.wreg_i;
        wdata_c    = bus.wdata_i;
        case (state_reg)
            LSU_IDLE, LSU_ACCESS: begin
                if (misaligned) begin
                    wreg_c  = 1'b0;
                    wdata_c = '0;
                end else if (is_mem) begin
                    addr_c  = ADDR_W'(bus.mem_addr_i) + ADDR_W'(byte_idx);
                    wdata_c = '0;
                    if (is_store) begin
                        wr_c   = 1'b1;
                        dout_c = bus.reg2_i[{byte_idx, 3'b000} +: 8];
                        if (byte_idx == sz) begin
                            state_next = LSU_IDLE;
                            cnt_next   = '0;
                        end else begin
                            stall_c    = 1'b1;
                            state_next = LSU_ACCESS;
                            cnt_next   = byte_idx + 2'd1;
                        end
                    end else begin
                        stall_c = 1'b1;
                        cap_en  = (byte_idx != 2'd0);
                        if (byte_idx == sz) begin
                            state_next = LSU_COLLECT;
                            cnt_next   = '0;
                        end else begin
                            state_next = LSU_ACCESS;
                            cnt_next   = byte_idx + 2'd1;
                        end
                    end
                end else begin
                    state_next = LSU_IDLE;
                    cnt_next   = '0;
                end
            end
            LSU_COLLECT: begin
                wdata_c    = load_data;
                state_next = LSU_IDLE;
                cnt_next   = '0;
            end
            default: begin
                state_next = LSU_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Outputs are forced low combinationally so reset acts immediately.
    assign bus.mem_stall  = rst & stall_c;
    assign bus.ram_wr_o   = rst & wr_c;
    assign bus.ram_addr_o = rst ? addr_c  : '0;
    assign bus.ram_dout_o = rst ? dout_c  : '0;
    assign bus.wd_o       = rst ? bus.wd_i : '0;
    assign bus.wreg_o     = rst & wreg_c;
    assign bus.wdata_o    = rst ? wdata_c : '0;

endmodule

// File: tb/tb_mem_lsu.sv
module tb_mem_lsu;
    import mem_lsu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_lsu_if #(.ADDR_W(32)) bus ();
    mem_lsu #(.ADDR_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    // Byte RAM: write on the edge, read data valid the following cycle.
    logic [7:0] ram [0:4095];
    always @(posedge clk) begin
        if (bus.ram_wr_o) ram[bus.ram_addr_o[11:0]] <= bus.ram_dout_o;
        bus.ram_din_i <= ram[bus.ram_addr_o[11:0]];
    end

    int checks = 0;
    int errors = 0;

    task automatic set_op(input op_bus_t op, input sub_op_bus_t sub, input logic [31:0] addr,
                          input logic [31:0] data, input logic [4:0] wd, input logic wreg,
                          input logic [31:0] wdata);
        bus.aluop_i = op; bus.sub_aluop_i = sub; bus.mem_addr_i = addr;
        bus.reg2_i = data; bus.wd_i = wd; bus.wreg_i = wreg; bus.wdata_i = wdata;
    endtask

    task automatic test_reset();
        set_op(EXE_SB, OP_SW, 32'h100, 32'hDEADBEEF, 5'd5, 1'b1, 32'h1111);
        #2;
        checks++; if (bus.mem_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", bus.mem_stall); end
        checks++; if (bus.ram_wr_o !== 1'b0) begin errors++; $display("FAIL reset_wr got=%b exp=0", bus.ram_wr_o); end
        checks++; if (bus.ram_addr_o !== 32'h0) begin errors++; $display("FAIL reset_addr got=%h exp=0", bus.ram_addr_o); end
        checks++; if (bus.ram_dout_o !== 8'h0) begin errors++; $display("FAIL reset_dout got=%h exp=0", bus.ram_dout_o); end
        checks++; if (bus.wd_o !== 5'd0) begin errors++; $display("FAIL reset_wd got=%0d exp=0", bus.wd_o); end
        checks++; if (bus.wreg_o !== 1'b0) begin errors++; $display("FAIL reset_wreg got=%b exp=0", bus.wreg_o); end
        checks++; if (bus.wdata_o !== 32'h0) begin errors++; $display("FAIL reset_wdata got=%h exp=0", bus.wdata_o); end
`ifdef MEM_LSU_MISALIGN_TRAP_EN
        checks++; if (bus.misalign_o !== 1'b0) begin errors++; $display("FAIL reset_misalign got=%b exp=0", bus.misalign_o); end
`endif
        repeat (2) @(negedge clk);
        rst = 1'b1;
        $display("reset released");
    endtask

    // Stores run back to back; each new op is presented the cycle after completion.
    task automatic test_store();
        sub_op_bus_t subs [3] = '{OP_SW, OP_SB, OP_SH};
        logic [31:0] addrs [3] = '{32'h100, 32'h200, 32'h210};
        logic [31:0] datas [3] = '{32'hDEADBEEF, 32'h12345678, 32'hCAFE8001};
        int          ns    [3] = '{4, 1, 2};
        for (int i = 0; i < 3; i++) begin
            set_op(EXE_SB, subs[i], addrs[i], datas[i], 5'd0, 1'b0, 32'h77);
            for (int c = 0; c < ns[i]; c++) begin
                #1;
                checks++; if (bus.ram_addr_o !== addrs[i] + c) begin errors++; $display("FAIL st%0d_addr c=%0d got=%h exp=%h", i, c, bus.ram_addr_o, addrs[i] + c); end
                checks++; if (bus.ram_wr_o !== 1'b1) begin errors++; $display("FAIL st%0d_wr c=%0d got=%b exp=1", i, c, bus.ram_wr_o); end
                checks++; if (bus.ram_dout_o !== 8'((datas[i] >> (8 * c)))) begin errors++; $display("FAIL st%0d_dout c=%0d got=%h exp=%h", i, c, bus.ram_dout_o, 8'((datas[i] >> (8 * c)))); end
                checks++; if (bus.mem_stall !== (c < ns[i] - 1)) begin errors++; $display("FAIL st%0d_stall c=%0d got=%b exp=%b", i, c, bus.mem_stall, (c < ns[i] - 1)); end
                checks++; if (bus.wdata_o !== 32'h0) begin errors++; $display("FAIL st%0d_wdata c=%0d got=%h exp=0", i, c, bus.wdata_o); end
                @(negedge clk);
            end
            $display("store %0d addr=%h data=%h n=%0d done", i, addrs[i], datas[i], ns[i]);
        end
    endtask

    task automatic test_load();
        sub_op_bus_t subs [6] = '{OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LH};
        logic [31:0] addrs [6] = '{32'h100, 32'h103, 32'h103, 32'h102, 32'h210, 32'h210};
        logic [31:0] exps  [6] = '{32'hDEADBEEF, 32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD,
                                  32'h00008001, 32'hFFFF8001};
        int          ns    [6] = '{4, 1, 1, 2, 2, 2};
        for (int i = 0; i < 6; i++) begin
            set_op(EXE_LB, subs[i], addrs[i], 32'h0, 5'(i + 1), 1'b1, 32'h99);
            for (int c = 0; c <= ns[i]; c++) begin
                #1;
                checks++; if (bus.mem_stall !== (c < ns[i])) begin errors++; $display("FAIL ld%0d_stall c=%0d got=%b exp=%b", i, c, bus.mem_stall, (c < ns[i])); end
                if (c < ns[i]) begin
                    checks++; if (bus.ram_addr_o !== addrs[i] + c) begin errors++; $display("FAIL ld%0d_addr c=%0d got=%h exp=%h", i, c, bus.ram_addr_o, addrs[i] + c); end
                    checks++; if (bus.ram_wr_o !== 1'b0) begin errors++; $display("FAIL ld%0d_wr c=%0d got=%b exp=0", i, c, bus.ram_wr_o); end
                end else begin
                    checks++; if (bus.wdata_o !== exps[i]) begin errors++; $display("FAIL ld%0d_data got=%h exp=%h", i, bus.wdata_o, exps[i]); end
                    checks++; if (bus.wd_o !== 5'(i + 1) || bus.wreg_o !== 1'b1) begin errors++; $display("FAIL ld%0d_wb got=%0d/%b exp=%0d/1", i, bus.wd_o, bus.wreg_o, i + 1); end
                end
                @(negedge clk);
            end
            $display("load %0d addr=%h exp=%h done", i, addrs[i], exps[i]);
        end
    endtask

    task automatic test_passthrough();
        set_op(EXE_SB, OP_SB, 32'h220, 32'h000000AB, 5'd0, 1'b0, 32'h0);
        #1;
        checks++; if (bus.mem_stall !== 1'b0 || bus.ram_wr_o !== 1'b1 || bus.ram_dout_o !== 8'hAB) begin errors++; $display("FAIL sb_single got stall=%b wr=%b dout=%h exp 0/1/ab", bus.mem_stall, bus.ram_wr_o, bus.ram_dout_o); end
        @(negedge clk);
        set_op(EXE_ARITH, OP_ADD, 32'h220, 32'h5, 5'd3, 1'b1, 32'h00001234);
        #1;
        checks++; if (bus.wdata_o !== 32'h00001234) begin errors++; $display("FAIL add_wdata got=%h exp=00001234", bus.wdata_o); end
        checks++; if (bus.wd_o !== 5'd3 || bus.wreg_o !== 1'b1) begin errors++; $display("FAIL add_wb got=%0d/%b exp=3/1", bus.wd_o, bus.wreg_o); end
        checks++; if (bus.mem_stall !== 1'b0 || bus.ram_wr_o !== 1'b0 || bus.ram_addr_o !== 32'h0 || bus.ram_dout_o !== 8'h0) begin errors++; $display("FAIL add_idle got stall=%b wr=%b addr=%h dout=%h exp all 0", bus.mem_stall, bus.ram_wr_o, bus.ram_addr_o, bus.ram_dout_o); end
        @(negedge clk);
        checks++; if (ram[12'h220] !== 8'hAB) begin errors++; $display("FAIL sb_ram got=%h exp=ab", ram[12'h220]); end
        $display("passthrough done");
    endtask

    task automatic test_reset_mid();
        set_op(EXE_SB, OP_SW, 32'h300, 32'h11223344, 5'd0, 1'b0, 32'h0);
        repeat (2) @(negedge clk);
        #1;
        checks++; if (bus.ram_addr_o !== 32'h302 || bus.ram_wr_o !== 1'b1) begin errors++; $display("FAIL mid_pre got addr=%h wr=%b exp 302/1", bus.ram_addr_o, bus.ram_wr_o); end
        #1 rst = 1'b0;
        #1;
        checks++; if (bus.ram_wr_o !== 1'b0 || bus.mem_stall !== 1'b0) begin errors++; $display("FAIL mid_drop got wr=%b stall=%b exp 0/0", bus.ram_wr_o, bus.mem_stall); end
        checks++; if (bus.ram_addr_o !== 32'h0 || bus.ram_dout_o !== 8'h0) begin errors++; $display("FAIL mid_bus got addr=%h dout=%h exp 0/0", bus.ram_addr_o, bus.ram_dout_o); end
        @(negedge clk);
        rst = 1'b1;
        set_op(EXE_LB, OP_LW, 32'h100, 32'h0, 5'd7, 1'b1, 32'h0);
        for (int c = 0; c <= 4; c++) begin
            #1;
            if (c < 4) begin
                checks++; if (bus.ram_addr_o !== 32'h100 + c || bus.mem_stall !== 1'b1) begin errors++; $display("FAIL mid_lw c=%0d got addr=%h stall=%b exp %h/1", c, bus.ram_addr_o, bus.mem_stall, 32'h100 + c); end
            end else begin
                checks++; if (bus.wdata_o !== 32'hDEADBEEF || bus.mem_stall !== 1'b0) begin errors++; $display("FAIL mid_lw_data got=%h stall=%b exp deadbeef/0", bus.wdata_o, bus.mem_stall); end
            end
            @(negedge clk);
        end
        $display("reset mid-access done");
    endtask

    task automatic test_misalign();
        set_op(EXE_LB, OP_LW, 32'h101, 32'h0, 5'd9, 1'b1, 32'h0);
`ifdef MEM_LSU_MISALIGN_TRAP_EN
        #1;
        checks++; if (bus.misalign_o !== 1'b1) begin errors++; $display("FAIL mis_flag got=%b exp=1", bus.misalign_o); end
        checks++; if (bus.ram_wr_o !== 1'b0 || bus.mem_stall !== 1'b0 || bus.wreg_o !== 1'b0) begin errors++; $display("FAIL mis_ctl got wr=%b stall=%b wreg=%b exp 0/0/0", bus.ram_wr_o, bus.mem_stall, bus.wreg_o); end
        @(negedge clk);
        set_op(EXE_ARITH, OP_ADD, 32'h0, 32'h0, 5'd1, 1'b1, 32'h42);
        #1;
        checks++; if (bus.misalign_o !== 1'b0 || bus.wdata_o !== 32'h42) begin errors++; $display("FAIL mis_clear got flag=%b wdata=%h exp 0/42", bus.misalign_o, bus.wdata_o); end
        @(negedge clk);
`else
        for (int c = 0; c <= 4; c++) begin
            #1;
            if (c < 4) begin
                checks++; if (bus.ram_addr_o !== 32'h101 + c || bus.ram_wr_o !== 1'b0 || bus.mem_stall !== 1'b1) begin errors++; $display("FAIL mis_lw c=%0d got addr=%h wr=%b stall=%b exp %h/0/1", c, bus.ram_addr_o, bus.ram_wr_o, bus.mem_stall, 32'h101 + c); end
            end else begin
                checks++; if (bus.wdata_o !== 32'h55DEADBE) begin errors++; $display("FAIL mis_lw_data got=%h exp=55deadbe", bus.wdata_o); end
            end
            @(negedge clk);
        end
`endif
        $display("misaligned LW at 0x101 done");
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
        ram[12'h104] = 8'h55;
        set_op(EXE_NOP, OP_NOP, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
        @(negedge clk);
        test_reset();
        test_store();
        test_load();
        test_passthrough();
        test_reset_mid();
        test_misalign();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
